phi2_bus_timing: RTL
====================

Name: phi2_bus_timing

Overview:
- Consumes the divided CPU clock (phi2) and converts it into single-cycle bus-timing strobes in the fpga_clk domain for the ROM/RAM emulation logic.
- Synchronises phi2 and detects its edges.
- Measures the high-phase length and times address-latch and data-valid strobes inside each phase.
- Provides a cycle counter and a lost-clock watchdog.

Parameters:
- SYNC_STAGES, 2, number of flops in the phi2 synchroniser (minimum 2).
- ADDR_DELAY, 2, fpga_clk cycles into the high phase at which addr_strobe fires (minimum 1).
- DATA_LEAD, 1, cycles before the predicted phi2 fall at which data_strobe fires.
- TIMEOUT, 200, fpga_clk cycles without any phi2 edge before clk_lost asserts (maximum 255).

Ports:
- fpga_clk  in  1  system clock, the only clock in the block.
- rst_n  in  1  asynchronous active-low reset.
- phi2_in  in  1  divided CPU clock, asynchronous to fpga_clk.
- phi2_rise  out  1  one-cycle pulse on a detected rising edge.
- phi2_fall  out  1  one-cycle pulse on a detected falling edge.
- phi2_sync  out  1  synchronised phi2 level.
- addr_strobe  out  1  one-cycle pulse: address bus is stable, latch it.
- data_strobe  out  1  one-cycle pulse: data must be valid or captured now.
- drive_window  out  1  level: high from addr_strobe until phi2_fall inclusive.
- high_len  out  8  length of the last completed high phase, in fpga_clk cycles.
- cycle_count  out  16  number of detected rising edges.
- clk_lost  out  1  watchdog flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops and state clear.
  - All outputs are 0, except clk_lost=1.
  - State goes to IDLE.
- Synchroniser and edge detection:
  - SYNC_STAGES flops feed a previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - All outputs are registered.
  - phi2_rise asserts exactly SYNC_STAGES+1 fpga_clk edges after the first edge that samples phi2_in high. phi2_fall follows the same rule.
- FSM states: IDLE, HIGH, LOW.
  - IDLE -> HIGH on a detected rise. Falls detected in IDLE are ignored.
  - HIGH -> LOW on a detected fall.
  - LOW -> HIGH on a detected rise.
  - HIGH or LOW -> IDLE on watchdog expiry.
- Phase counter hcnt (8 bits, saturates at 255):
  - Loads 1 in the cycle phi2_rise is asserted.
  - Increments every cycle while in HIGH.
  - On phi2_fall, high_len <= hcnt. This is the number of cycles phi2_sync was high.
- addr_strobe:
  - Pulses in the cycle where state is HIGH and hcnt == ADDR_DELAY.
  - If the fall arrives first, it is suppressed for that cycle.
- data_strobe:
  - target = max(high_len - DATA_LEAD, ADDR_DELAY), computed from the previous high_len.
  - Pulses when HIGH and hcnt == target.
  - If high_len == 0 (no measurement yet) or target is never reached, it pulses together with phi2_fall instead.
  - Exactly one data_strobe per high phase.
- drive_window:
  - Sets on addr_strobe and clears in the cycle after phi2_fall.
  - Forced to 0 in IDLE.
- cycle_count: +1 on each phi2_rise; wraps 65535 -> 0.
- Watchdog (8-bit counter):
  - Clears on every detected edge; otherwise increments.
  - Reaching TIMEOUT: clk_lost <= 1, state <= IDLE, high_len <= 0, hcnt <= 0.
  - No strobes are produced while in IDLE.
  - clk_lost clears in the cycle phi2_rise asserts.
  - cycle_count is not cleared by the watchdog.
- Simultaneous events: a watchdog expiry and an edge in the same cycle resolve to the edge, because the watchdog clear wins.
- Reset mid-phase: aborts immediately, with no trailing pulses after release.

Decomposition:
- Package phi2_timing_pkg holds:
  - the state enum (IDLE/HIGH/LOW);
  - the widths HCNT_W=8 and CYC_W=16.
- One sub-module, phi2_sync_edge:
  - contains the SYNC_STAGES synchroniser plus prev register;
  - outputs sync, rise and fall.
  - It is reusable for other asynchronous bus inputs.

Test Plan:
- Reset, then phi2_in toggling every 4 fpga_clk cycles (the clockgen output with CLKS_PER_CYCLE=3):
  - first phi2_rise arrives 3 edges after the input rise;
  - clk_lost clears;
  - addr_strobe at hcnt=2;
  - first data_strobe coincides with phi2_fall;
  - high_len=4.
- Second and later phases of the same stimulus:
  - data_strobe at hcnt=3 (4-1);
  - drive_window high from addr_strobe through phi2_fall;
  - cycle_count increments by 1 per phase.
- Single high phase of 1 cycle:
  - phi2_rise, then phi2_fall;
  - no addr_strobe;
  - data_strobe with phi2_fall;
  - high_len=1.
- phi2_in held constant for 200 cycles after activity:
  - clk_lost=1, high_len=0, no strobes;
  - next rise clears clk_lost and cycle_count continues from its old value.
- Preload cycle_count to 65535 (65535 rises or force), then one rise -> cycle_count=0.
- rst_n pulsed low mid-high-phase:
  - all outputs 0 asynchronously, clk_lost=1;
  - after release, no strobe until a fresh rise is detected.

Source files
------------

// File: rtl/phi2_timing_pkg.sv
// Shared types and widths for the phi2 bus-timing block.
package phi2_timing_pkg;

  localparam int HCNT_W = 8;
  localparam int CYC_W  = 16;

  // IDLE: no trusted clock; HIGH/LOW: tracking the current phi2 phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } phase_state_t;

endpackage

// File: rtl/phi2_bus_timing_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses.
// Reusable for any asynchronous single-bit input. 'sync' is the registered
// previous value, so it is time-aligned with the rise/fall pulses.
module phi2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fpga_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sreg;
  logic                   prev;
  logic                   rise_q;
  logic                   fall_q;

  // Shift the input through the synchroniser and register the edge pulses.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      prev   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sreg   <= {sreg[SYNC_STAGES-2:0], async_in};
      prev   <= sreg[SYNC_STAGES-1];
      rise_q <= sreg[SYNC_STAGES-1] & ~prev;
      fall_q <= ~sreg[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = prev;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/phi2_bus_timing.sv
// Converts the asynchronous phi2 clock into fpga_clk-domain bus strobes:
// edge pulses, address-latch and data-valid strobes, a drive window,
// the measured high-phase length, a rise counter and a lost-clock watchdog.
module phi2_bus_timing
  import phi2_timing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_DELAY  = 2,
  parameter int DATA_LEAD   = 1,
  parameter int TIMEOUT     = 200
) (
  input  logic              fpga_clk,
  input  logic              rst_n,
  input  logic              phi2_in,
  output logic              phi2_rise,
  output logic              phi2_fall,
  output logic              phi2_sync,
  output logic              addr_strobe,
  output logic              data_strobe,
  output logic              drive_window,
  output logic [HCNT_W-1:0] high_len,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              clk_lost
);

  localparam logic [HCNT_W-1:0] ADDR_D  = HCNT_W'(ADDR_DELAY);
  localparam logic [HCNT_W-1:0] LEAD_D  = HCNT_W'(DATA_LEAD);
  localparam logic [HCNT_W:0]   TGT_LIM = (HCNT_W+1)'(ADDR_DELAY + DATA_LEAD);
  localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);

  phase_state_t      state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] high_len_q;
  logic [HCNT_W-1:0] target;
  logic [CYC_W-1:0]  cyc_cnt_q;
  logic [7:0]        wd_q;
  logic              lost_q;
  logic              win_q;
  logic              data_done_q;
  logic              in_high;
  logic              edge_seen;
  logic              expire;

  phi2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .fpga_clk (fpga_clk),
    .rst_n    (rst_n),
    .async_in (phi2_in),
    .sync     (phi2_sync),
    .rise     (phi2_rise),
    .fall     (phi2_fall)
  );

  assign in_high   = (state_q == HIGH);
  assign edge_seen = phi2_rise | phi2_fall;
  // An edge in the expiry cycle clears the watchdog, so the edge wins.
  assign expire    = !edge_seen && (wd_q == WD_LAST);

  // Data strobe target: max(previous high_len - DATA_LEAD, ADDR_DELAY), underflow-safe.
  always_comb begin
    target = ADDR_D;
    if ({1'b0, high_len_q} > TGT_LIM) target = high_len_q - LEAD_D;
  end

  // Phase tracking next state; watchdog expiry overrides to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (phi2_rise) state_d = HIGH;
      HIGH:    if (phi2_fall) state_d = LOW;
      LOW:     if (phi2_rise) state_d = HIGH;
      default: state_d = IDLE;
    endcase
    if (expire) state_d = IDLE;
  end

  // Strobes are decoded from registered state only; nothing fires outside HIGH.
  assign addr_strobe  = in_high && (hcnt_q == ADDR_D) && !phi2_fall;
  assign data_strobe  = in_high && !data_done_q &&
                        (phi2_fall || ((high_len_q != '0) && (hcnt_q == target)));
  assign drive_window = (state_q != IDLE) && (addr_strobe || win_q);

  // State, phase counter, measurement, rise counter and watchdog registers.
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      high_len_q  <= '0;
      cyc_cnt_q   <= '0;
      wd_q        <= '0;
      lost_q      <= 1'b1;
      win_q       <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (edge_seen)            wd_q <= '0;
      else if (wd_q != 8'hFF)   wd_q <= wd_q + 8'd1;

      if (phi2_rise) cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);

      if (expire) begin
        lost_q      <= 1'b1;
        high_len_q  <= '0;
        hcnt_q      <= '0;
        win_q       <= 1'b0;
        data_done_q <= 1'b0;
      end else begin
        if (phi2_rise) begin
          hcnt_q      <= HCNT_W'(1);
          lost_q      <= 1'b0;
          win_q       <= 1'b0;
          data_done_q <= 1'b0;
        end else if (in_high && hcnt_q != '1) begin
          hcnt_q <= hcnt_q + HCNT_W'(1);
        end

        if (in_high && phi2_fall) begin
          high_len_q <= hcnt_q;
          win_q      <= 1'b0;
        end else if (addr_strobe) begin
          win_q <= 1'b1;
        end

        if (data_strobe) data_done_q <= 1'b1;
      end
    end
  end

  assign high_len    = high_len_q;
  assign cycle_count = cyc_cnt_q;
  assign clk_lost    = lost_q;

endmodule
